// File: rtl/signed_bcd_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and constants for the signed BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam logic [3:0] BCD_MINUS  = 4'd10;
    localparam logic [3:0] BCD_BLANK  = 4'd11;
    localparam int         BCD_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/signed_bcd_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : signed_bcd_converter_if
//  Description : Request/result bundle between a requester (master) and the
//                converter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface signed_bcd_converter_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             negative_sign;
    logic [3:0]       dig2;
    logic [3:0]       dig1;
    logic [3:0]       dig0;

    modport master (
        output start, value,
        input  busy, done, negative_sign, dig2, dig1, dig0
    );

    modport slave (
        input  start, value,
        output busy, done, negative_sign, dig2, dig1, dig0
    );
endinterface
`default_nettype wire

// File: rtl/signed_bcd_converter_bcd_add3_stage.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3_stage
//  Description : Double-dabble digit correction: add 3 when the digit is >= 5
//                so the following left shift carries correctly into the next
//                decade.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_stage (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Correct a single scratch digit ahead of the shift
    always_comb begin
        digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
    end

endmodule
`default_nettype wire

// File: rtl/signed_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : signed_bcd_converter
//  Description : Sequential two's-complement to sign + 3-digit BCD converter
//                using one double-dabble iteration per clock.
//                Optional macro BCD_LEADING_BLANK_EN replaces leading zero
//                digits (hundreds, tens) with the blank code.
//  Revision    : 1.0 - initial release
// ============================================================================
import bcd_pkg::*;

module signed_bcd_converter #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    signed_bcd_converter_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * BCD_DIGITS;

    state_e           state;
    logic             sign_q;
    logic [WIDTH-1:0] mag_q;
    logic [SW-1:0]    scratch_q;
    logic [SW-1:0]    scratch_adj;
    logic [CW-1:0]    iter_q;
    logic [WIDTH-1:0] mag_in;

    logic             done_q;
    logic             neg_q;
    logic [3:0]       dig2_q;
    logic [3:0]       dig1_q;
    logic [3:0]       dig0_q;

    // Magnitude of the incoming value; the most negative input wraps to its
    // correct unsigned magnitude because the result is WIDTH bits unsigned.
    always_comb begin
        mag_in = bus.value[WIDTH-1] ? (WIDTH'(0) - bus.value) : bus.value;
    end

    generate
        for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
            bcd_add3_stage u_stage (
                .digit_in  (scratch_q[4*i +: 4]),
                .digit_out (scratch_adj[4*i +: 4])
            );
        end
    endgenerate

    // Control FSM and double-dabble datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    // A start in FINISH is accepted so back-to-back requests
                    // are serviced without an idle gap.
                    if (bus.start) begin
                        sign_q    <= bus.value[WIDTH-1];
                        mag_q     <= mag_in;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        state     <= ST_CONVERT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    // The top scratch bit is always clear for |value| <= 512,
                    // so it can be dropped by the shift.
                    {scratch_q, mag_q} <= {scratch_adj[SW-2:0], mag_q, 1'b0};
                    iter_q             <= iter_q + 1'b1;
                    if (iter_q == CW'(WIDTH - 1)) begin
                        state <= ST_FINISH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result registers: loaded once per conversion, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            dig2_q <= 4'd0;
            dig1_q <= 4'd0;
            dig0_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_FINISH) begin
                done_q <= 1'b1;
                // A zero magnitude never reports a minus sign
                neg_q  <= sign_q & (|scratch_q);
                dig0_q <= scratch_q[3:0];
`ifdef BCD_LEADING_BLANK_EN
                dig2_q <= (scratch_q[11:8] == 4'd0) ? BCD_BLANK : scratch_q[11:8];
                dig1_q <= ((scratch_q[11:8] == 4'd0) && (scratch_q[7:4] == 4'd0))
                          ? BCD_BLANK : scratch_q[7:4];
`else
                dig2_q <= scratch_q[11:8];
                dig1_q <= scratch_q[7:4];
`endif
            end
        end
    end

    assign bus.busy          = (state == ST_CONVERT);
    assign bus.done          = done_q;
    assign bus.negative_sign = neg_q;
    assign bus.dig2          = dig2_q;
    assign bus.dig1          = dig1_q;
    assign bus.dig0          = dig0_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_bcd_converter
//  Description : Self-checking bench for signed_bcd_converter (WIDTH=8) with
//                an arithmetic reference model; honours BCD_LEADING_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_bcd_converter;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    signed_bcd_converter_if #(.WIDTH(WIDTH)) bus ();

    signed_bcd_converter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sign + decimal digits from plain integer arithmetic
    task automatic model(input logic [WIDTH-1:0] v, output int s, output int d2,
                         output int d1, output int d0);
        int sv;
        int m;
        sv = int'($signed(v));
        m  = (sv < 0) ? -sv : sv;
        s  = (m != 0 && sv < 0) ? 1 : 0;
        d2 = m / 100;
        d1 = (m / 10) % 10;
        d0 = m % 10;
`ifdef BCD_LEADING_BLANK_EN
        if (m < 100) d2 = 11;
        if (m < 10)  d1 = 11;
`endif
    endtask

    task automatic check_result(input string tag, input int s, input int d2,
                                input int d1, input int d0);
        chk({tag, "_sign"}, 32'(bus.negative_sign), s);
        chk({tag, "_dig2"}, 32'(bus.dig2), d2);
        chk({tag, "_dig1"}, 32'(bus.dig1), d1);
        chk({tag, "_dig0"}, 32'(bus.dig0), d0);
    endtask

    task automatic convert(input logic [WIDTH-1:0] v);
        int s, d2, d1, d0, n;
        model(v, s, d2, d1, d0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = WIDTH'($urandom);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            chk("busy_during", 32'(bus.busy), (n <= 7) ? 1 : 0);
            chk("no_early_done", 32'(bus.done), 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 9);
        check_result("conv", s, d2, d1, d0);
        @(posedge clk);
        #1;
        chk("done_single", 32'(bus.done), 0);
        check_result("hold", s, d2, d1, d0);
    endtask

    initial begin
        int s, d2, d1, d0, cnt, first_at, second_at;
        vectors     = 0;
        miscompares = 0;
        bus.start   = 1'b0;
        bus.value   = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        check_result("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed boundary values
        convert(8'd0);
        convert(8'd127);
        convert(8'h80);
        convert(8'hFB);
        convert(8'd40);
        convert(8'hFF);

        // Randomised values
        for (int i = 0; i < 12; i++) begin
            convert(WIDTH'($urandom));
        end

        // start held high: conversions back-to-back via the FINISH cycle
        model(8'd99, s, d2, d1, d0);
        cnt = 0; first_at = -1; second_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 8'd99;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                cnt++;
                if (first_at < 0) first_at = k; else second_at = k;
                check_result("held", s, d2, d1, d0);
            end
        end
        bus.start = 1'b0;
        chk("held_count", cnt, 2);
        chk("held_first", first_at, 9);
        chk("held_second", second_at, 18);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // start while busy is ignored
        model(8'd77, s, d2, d1, d0);
        cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 8'd77;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k < 16; k++) begin
            if (k == 4) begin
                bus.start = 1'b1;
                bus.value = 8'hFF;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                cnt++;
                check_result("busy_ign", s, d2, d1, d0);
            end
        end
        chk("busy_ign_count", cnt, 1);

        // Reset mid-conversion, asserted between clock edges
        convert(8'h80);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 8'd55;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        check_result("abort", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        convert(WIDTH'($urandom));
        convert(8'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
